// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: coprocessor-0 exception/interrupt unit for the pipelined MIPS core.
// Holds SR(12), Cause(13), EPC(14) and PRId(15), makes the take-exception decision
// for the M stage, and serves mfc0/mtc0/eret.
// Optional feature: define CP0_BADVADDR_EN to add BadVAddr (reg 8) and the
// bad_vaddr_m input. It is captured on address-error exceptions (ExcCode 4/5).
module cp0_exc_unit #(
  parameter logic [31:0] PRID       = 32'h0000_2019,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        cp0_we,
  input  logic        eret_m,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] bad_vaddr_m,
`endif
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic [31:0] exc_pc,
  output logic [31:0] epc_out
);

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  // EPC, with bits [1:0] held at zero
  logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
`endif

  logic        int_req_s;
  logic        err_req_s;
  logic        exc_req_s;
  logic [31:0] epc_target_s;
  logic        sr_wr_s;
  logic        epc_wr_s;
  logic        exl_wr_s;

  // Request decision: interrupts beat errors, and EXL masks both; nothing is requested in reset.
  always_comb begin
    int_req_s = (|(hw_int & im_q)) & ie_q & ~exl_q;
    err_req_s = (exc_code_in != 4'd0) & ~exl_q;
    exc_req_s = (int_req_s | err_req_s) & reset;
    // The slot instruction restarts at the branch, so step back one word; wraps at 0.
    epc_target_s = (bd_m ? (pc_m - 32'd4) : pc_m) & 32'hFFFF_FFFC;
    sr_wr_s   = cp0_we & ~exc_req_s & (cp0_addr == 5'd12);
    epc_wr_s  = cp0_we & ~exc_req_s & (cp0_addr == 5'd14);
    exl_wr_s  = sr_wr_s ? cp0_wdata[1] : exl_q;
  end

  // Next-state for all CP0 registers: exception entry overrides mtc0; eret overrides a written EXL.
  always_comb begin
    im_d      = im_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    bd_d      = bd_q;
    ip_d      = hw_int;
    exccode_d = exccode_q;
    epc_d     = epc_q;
`ifdef CP0_BADVADDR_EN
    badvaddr_d = badvaddr_q;
`endif
    if (exc_req_s) begin
      exl_d     = 1'b1;
      exccode_d = int_req_s ? 5'd0 : {1'b0, exc_code_in};
      bd_d      = bd_m;
      epc_d     = epc_target_s;
`ifdef CP0_BADVADDR_EN
      if (!int_req_s && ((exc_code_in == 4'd4) || (exc_code_in == 4'd5))) begin
        badvaddr_d = bad_vaddr_m;
      end else begin
        badvaddr_d = badvaddr_q;
      end
`endif
    end else begin
      im_d  = sr_wr_s ? cp0_wdata[15:10] : im_q;
      ie_d  = sr_wr_s ? cp0_wdata[0] : ie_q;
      exl_d = eret_m ? 1'b0 : exl_wr_s;
      epc_d = epc_wr_s ? {cp0_wdata[31:2], 2'b00} : epc_q;
    end
  end

  // CP0 register state, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q      <= 6'd0;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= 32'd0;
`endif
    end else begin
      im_q      <= im_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

  // mfc0 read mux; unmapped numbers read zero.
  always_comb begin
    case (cp0_addr)
`ifdef CP0_BADVADDR_EN
      5'd8:    cp0_rdata = badvaddr_q;
`endif
      5'd12:   cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
      5'd14:   cp0_rdata = epc_q;
      5'd15:   cp0_rdata = PRID;
      default: cp0_rdata = 32'd0;
    endcase
  end

  // EPC to the PC logic, forwarding an in-flight mtc0 EPC so eret in the same cycle sees it.
  always_comb begin
    if (!reset) begin
      epc_out = 32'd0;
    end else if (cp0_we && (cp0_addr == 5'd14)) begin
      epc_out = {cp0_wdata[31:2], 2'b00};
    end else begin
      epc_out = epc_q;
    end
  end

  assign exc_req = exc_req_s;
  assign exc_pc  = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed testbench for cp0_exc_unit; expected values are hand-computed constants.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        cp0_we;
  logic        eret_m;
  logic [31:0] bad_vaddr_m;
  logic [31:0] cp0_rdata;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic [31:0] epc_out;

  int checks_cnt;
  int errors_cnt;

  cp0_exc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .pc_m        (pc_m),
    .bd_m        (bd_m),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_we      (cp0_we),
    .eret_m      (eret_m),
`ifdef CP0_BADVADDR_EN
    .bad_vaddr_m (bad_vaddr_m),
`endif
    .cp0_rdata   (cp0_rdata),
    .exc_req     (exc_req),
    .exc_pc      (exc_pc),
    .epc_out     (epc_out)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read a CP0 register through the combinational mfc0 path.
  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp_v);
    cp0_addr = addr;
    #1;
    chk(tag, cp0_rdata, exp_v);
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    reset       = 1'b0;
    exc_code_in = 4'd0;
    hw_int      = 6'd0;
    pc_m        = 32'd0;
    bd_m        = 1'b0;
    cp0_addr    = 5'd0;
    cp0_wdata   = 32'd0;
    cp0_we      = 1'b0;
    eret_m      = 1'b0;
    bad_vaddr_m = 32'd0;

    // Reset state
    #2;
    rd_chk("rst_sr", 5'd12, 32'd0);
    rd_chk("rst_cause", 5'd13, 32'd0);
    rd_chk("rst_epc", 5'd14, 32'd0);
    rd_chk("prid", 5'd15, 32'h0000_2019);
    chk("rst_exc_req", {31'd0, exc_req}, 32'd0);
    chk("exc_pc", exc_pc, 32'h0000_4180);
    tick();
    reset = 1'b1;

    // 1: enable interrupts, then raise IP4
    cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01; cp0_we = 1'b1;
    tick();
    cp0_we = 1'b0;
    rd_chk("t1_sr_wr", 5'd12, 32'h0000_FC01);
    hw_int = 6'b000100; pc_m = 32'h0000_1000;
    #1;
    chk("t1_req", {31'd0, exc_req}, 32'd1);
    tick();
    rd_chk("t1_cause", 5'd13, 32'h0000_1000);
    rd_chk("t1_sr", 5'd12, 32'h0000_FC03);
    rd_chk("t1_epc", 5'd14, 32'h0000_1000);
    chk("t1_masked", {31'd0, exc_req}, 32'd0);
    hw_int = 6'd0; eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    rd_chk("t1_eret_sr", 5'd12, 32'h0000_FC01);

    // 2: overflow in a delay slot
    exc_code_in = 4'd12; pc_m = 32'h0000_3010; bd_m = 1'b1;
    #1;
    chk("t2_req", {31'd0, exc_req}, 32'd1);
    tick();
    exc_code_in = 4'd0; bd_m = 1'b0;
    rd_chk("t2_epc", 5'd14, 32'h0000_300C);
    rd_chk("t2_cause", 5'd13, 32'h8000_0030);

    // 3: requests masked by EXL, interrupt fires after eret
    exc_code_in = 4'd10; hw_int = 6'h3F;
    #1;
    chk("t3_masked", {31'd0, exc_req}, 32'd0);
    tick();
    exc_code_in = 4'd0;
    rd_chk("t3_epc", 5'd14, 32'h0000_300C);
    rd_chk("t3_cause_ip", 5'd13, 32'h8000_FC30);
    eret_m = 1'b1;
    #1;
    chk("t3_eret_cyc", {31'd0, exc_req}, 32'd0);
    tick();
    eret_m = 1'b0; pc_m = 32'h0000_2000;
    #1;
    chk("t3_int_fire", {31'd0, exc_req}, 32'd1);
    tick();
    hw_int = 6'd0;
    rd_chk("t3_cause", 5'd13, 32'h0000_FC00);
    rd_chk("t3_epc2", 5'd14, 32'h0000_2000);

    // 4: mtc0 EPC forwarded while eret executes
    cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007; cp0_we = 1'b1; eret_m = 1'b1;
    #1;
    chk("t4_fwd", epc_out, 32'h0000_3004);
    tick();
    cp0_we = 1'b0; eret_m = 1'b0;
    rd_chk("t4_sr", 5'd12, 32'h0000_FC01);
    rd_chk("t4_epc", 5'd14, 32'h0000_3004);
    chk("t4_epc_out", epc_out, 32'h0000_3004);

    // 5: AdEL with a simultaneous mtc0 SR=0, which must be dropped
    exc_code_in = 4'd4; pc_m = 32'h0000_4004; bad_vaddr_m = 32'hDEAD_BEE1;
    cp0_addr = 5'd12; cp0_wdata = 32'd0; cp0_we = 1'b1;
    #1;
    chk("t5_req", {31'd0, exc_req}, 32'd1);
    tick();
    exc_code_in = 4'd0; cp0_we = 1'b0;
    rd_chk("t5_sr", 5'd12, 32'h0000_FC03);
    rd_chk("t5_cause", 5'd13, 32'h0000_0010);
    rd_chk("t5_epc", 5'd14, 32'h0000_4004);
`ifdef CP0_BADVADDR_EN
    rd_chk("t5_badva", 5'd8, 32'hDEAD_BEE1);
`else
    rd_chk("t5_reg8", 5'd8, 32'd0);
`endif

    // Boundary: delay-slot PC of 0 wraps; Cause is not writable
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    exc_code_in = 4'd5; pc_m = 32'd0; bd_m = 1'b1; bad_vaddr_m = 32'h1234_5678;
    tick();
    exc_code_in = 4'd0; bd_m = 1'b0;
    rd_chk("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd_chk("wrap_cause", 5'd13, 32'h8000_0014);
`ifdef CP0_BADVADDR_EN
    rd_chk("wrap_badva", 5'd8, 32'h1234_5678);
`endif
    cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF; cp0_we = 1'b1;
    tick();
    cp0_we = 1'b0;
    rd_chk("cause_ro", 5'd13, 32'h8000_0014);

    // 6: asynchronous reset mid-exception, with an error code still presented
    @(posedge clk);
    #3;
    exc_code_in = 4'd4;
    reset = 1'b0;
    rd_chk("t6_sr", 5'd12, 32'd0);
    rd_chk("t6_cause", 5'd13, 32'd0);
    rd_chk("t6_epc", 5'd14, 32'd0);
    chk("t6_req", {31'd0, exc_req}, 32'd0);
    chk("t6_epc_out", epc_out, 32'd0);
    tick();
    exc_code_in = 4'd0;
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
